// File: rtl/dcpu_pkg.sv
// Shared DCPU definitions: default bus widths and the fetch-responder state encoding.
// The CPU control FSM imports this package to decode the fetch state.
package dcpu_pkg;

    localparam int unsigned DCPU_ADDR_WIDTH = 16;
    localparam int unsigned DCPU_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        FETCH_IDLE     = 2'd0,
        FETCH_MEM_REQ  = 2'd1,
        FETCH_MEM_WAIT = 2'd2,
        FETCH_RESPOND  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/dcpu_fetch_resp.sv
// Instruction fetch responder with a single-entry last-word buffer and a timed memory read.
// All outputs are registered and change only on the rising edge of i_clk.
module dcpu_fetch_resp
    import dcpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DCPU_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DCPU_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_fetch,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_instruction,
    output logic                  o_instruction_valid,
    output logic                  o_fetch_error,
    output logic                  o_busy,
    output logic                  o_mem_rd,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic                  i_mem_ack
);

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    fetch_state_e          state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] buf_tag_q;
    logic [DATA_WIDTH-1:0] buf_data_q;
    logic                  buf_valid_q;
    logic [7:0]            wait_cnt_q;
    logic [7:0]            wait_cnt_d;
    logic                  buf_hit;

    logic [DATA_WIDTH-1:0] instr_q;
    logic                  valid_q;
    logic                  error_q;
    logic                  busy_q;
    logic                  mem_rd_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    always_comb begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        buf_hit    = buf_valid_q && (buf_tag_q == i_addr) && !i_flush;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= FETCH_IDLE;
            addr_q      <= '0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            buf_valid_q <= 1'b0;
            wait_cnt_q  <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            mem_rd_q <= 1'b0;
            if (i_flush) begin
                buf_valid_q <= 1'b0;
            end

            case (state_q)
                FETCH_IDLE: begin
                    if (i_fetch) begin
                        addr_q <= i_addr;
                        busy_q <= 1'b1;
                        if (buf_hit) begin
                            state_q <= FETCH_RESPOND;
                            instr_q <= buf_data_q;
                            valid_q <= 1'b1;
                        end else begin
                            state_q    <= FETCH_MEM_REQ;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= i_addr;
                        end
                    end
                end
                FETCH_MEM_REQ: begin
                    state_q    <= FETCH_MEM_WAIT;
                    wait_cnt_q <= '0;
                end
                FETCH_MEM_WAIT: begin
                    // An ack on the final allowed wait cycle still wins over the timeout.
                    if (i_mem_ack) begin
                        state_q     <= FETCH_RESPOND;
                        instr_q     <= i_mem_data;
                        valid_q     <= 1'b1;
                        buf_data_q  <= i_mem_data;
                        buf_tag_q   <= addr_q;
                        buf_valid_q <= !i_flush;
                    end else if (wait_cnt_d == TIMEOUT_CNT) begin
                        state_q    <= FETCH_RESPOND;
                        wait_cnt_q <= wait_cnt_d;
                        instr_q    <= '0;
                        valid_q    <= 1'b1;
                        error_q    <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                FETCH_RESPOND: begin
                    state_q <= FETCH_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= FETCH_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_instruction       = instr_q;
    assign o_instruction_valid = valid_q;
    assign o_fetch_error       = error_q;
    assign o_busy              = busy_q;
    assign o_mem_rd            = mem_rd_q;
    assign o_mem_addr          = mem_addr_q;

endmodule

// File: tb/tb_dcpu_fetch_resp.sv
// Self-checking bench for dcpu_fetch_resp: directed scenarios plus randomized fetch traffic
// checked against a transaction-level model of the last-word buffer.
module tb_dcpu_fetch_resp;

    localparam int unsigned T = 6;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_fetch = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_flush = 1'b0;
    logic [15:0] o_instruction;
    logic        o_instruction_valid;
    logic        o_fetch_error;
    logic        o_busy;
    logic        o_mem_rd;
    logic [15:0] o_mem_addr;
    logic [15:0] i_mem_data = '0;
    logic        i_mem_ack = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    // Transaction-level model of the last-word buffer.
    logic        m_valid = 1'b0;
    logic [15:0] m_tag = '0;
    logic [15:0] m_data = '0;

    dcpu_fetch_resp #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(T)) dut (
        .i_clk               (i_clk),
        .i_reset             (i_reset),
        .i_fetch             (i_fetch),
        .i_addr              (i_addr),
        .i_flush             (i_flush),
        .o_instruction       (o_instruction),
        .o_instruction_valid (o_instruction_valid),
        .o_fetch_error       (o_fetch_error),
        .o_busy              (o_busy),
        .o_mem_rd            (o_mem_rd),
        .o_mem_addr          (o_mem_addr),
        .i_mem_data          (i_mem_data),
        .i_mem_ack           (i_mem_ack)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Expected outcome of one fetch, from the buffer rules; updates the model buffer.
    task automatic predict(input logic [15:0] addr, input bit flush, input int ack_wait,
                           input logic [15:0] data, input bit flush_at_ack,
                           output int lat, output int rd, output logic [15:0] instr,
                           output logic err);
        bit hit;
        hit = m_valid && (m_tag == addr) && !flush;
        if (flush) m_valid = 1'b0;
        if (hit) begin
            lat = 1; rd = 0; instr = m_data; err = 1'b0;
        end else if (ack_wait >= 0 && ack_wait < int'(T)) begin
            lat = 3 + ack_wait; rd = 1; instr = data; err = 1'b0;
            m_tag = addr; m_data = data; m_valid = !flush_at_ack;
        end else begin
            lat = 2 + int'(T); rd = 1; instr = '0; err = 1'b1;
        end
    endtask

    // Drives one fetch starting in an IDLE cycle and records what the DUT did.
    task automatic run_fetch(input logic [15:0] addr, input bit flush, input int ack_wait,
                             input logic [15:0] data, input bit spurious, input bit flush_at_ack,
                             input int refetch_cyc,
                             output int lat, output int rd_cnt, output logic [15:0] rd_addr,
                             output logic [15:0] instr, output logic err, output int extra,
                             output logic busy_c1, output logic busy_after,
                             output logic [15:0] instr_after);
        int rd_cyc;
        lat = -1; rd_cnt = 0; rd_cyc = -1; rd_addr = '0; instr = '0; err = 1'b0;
        extra = 0; busy_c1 = 1'b0; busy_after = 1'b1; instr_after = '0;
        i_fetch = 1'b1; i_addr = addr; i_flush = flush; i_mem_ack = 1'b0;
        for (int c = 1; c <= int'(T) + 20; c++) begin
            tick;
            i_fetch = 1'b0; i_flush = 1'b0; i_mem_ack = 1'b0; i_mem_data = 16'($urandom);
            if (c == 1) busy_c1 = o_busy;
            if (o_mem_rd) begin
                rd_cnt++; rd_cyc = c; rd_addr = o_mem_addr;
                if (spurious) i_mem_ack = 1'b1;
            end
            if (o_instruction_valid) begin
                if (lat < 0) begin
                    lat = c; instr = o_instruction; err = o_fetch_error;
                end else begin
                    extra++;
                end
            end
            if (c == refetch_cyc) begin
                i_fetch = 1'b1; i_addr = 16'h0030;
            end
            if (ack_wait >= 0 && rd_cyc > 0 && c == rd_cyc + 1 + ack_wait) begin
                i_mem_ack = 1'b1; i_mem_data = data; i_flush = flush_at_ack;
            end
            if (lat > 0 && c == lat + 1) begin
                busy_after = o_busy; instr_after = o_instruction;
            end
            if (lat > 0 && c >= lat + 3) break;
        end
        i_fetch = 1'b0; i_flush = 1'b0; i_mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        i_reset = 1'b1; i_fetch = 1'b1; i_addr = 16'h0010; i_mem_ack = 1'b1; i_mem_data = 16'hFFFF;
        tick; tick; tick;
        n_cmp++;
        if ({o_instruction, o_instruction_valid, o_fetch_error, o_busy, o_mem_rd, o_mem_addr} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got instr=%h v=%b e=%b busy=%b rd=%b maddr=%h, want all zero",
                     o_instruction, o_instruction_valid, o_fetch_error, o_busy, o_mem_rd, o_mem_addr);
        end
        i_reset = 1'b0; i_fetch = 1'b0; i_mem_ack = 1'b0;
        tick;
        n_cmp++;
        if ({o_busy, o_mem_rd, o_instruction_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%b rd=%b v=%b, want 000", o_busy, o_mem_rd, o_instruction_valid);
        end
        m_valid = 1'b0;
    endtask

    task automatic test_miss;
        int lat, rd, extra, elat, erd;
        logic [15:0] ra, ins, ia, eins;
        logic er, b1, ba, eer;
        predict(16'h0010, 1'b0, 0, 16'hA5A5, 1'b0, elat, erd, eins, eer);
        run_fetch(16'h0010, 1'b0, 0, 16'hA5A5, 1'b0, 1'b0, -1, lat, rd, ra, ins, er, extra, b1, ba, ia);
        n_cmp++;
        if (lat !== 3 || lat !== elat) begin
            n_fail++; $display("FAIL miss_latency: got %0d, want 3", lat);
        end
        n_cmp++;
        if (rd !== 1 || ra !== 16'h0010) begin
            n_fail++; $display("FAIL miss_mem_rd: got count=%0d addr=%h, want 1 / 0010", rd, ra);
        end
        n_cmp++;
        if (ins !== 16'hA5A5 || er !== 1'b0) begin
            n_fail++; $display("FAIL miss_data: got %h err=%b, want a5a5 err=0", ins, er);
        end
        n_cmp++;
        if (b1 !== 1'b1 || ba !== 1'b0 || extra !== 0 || ia !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL miss_busy_hold: got busy1=%b busy_after=%b extra=%0d held=%h, want 1 0 0 a5a5", b1, ba, extra, ia);
        end
    endtask

    task automatic test_hit;
        int lat, rd, extra, elat, erd;
        logic [15:0] ra, ins, ia, eins;
        logic er, b1, ba, eer;
        predict(16'h0010, 1'b0, 0, 16'h0000, 1'b0, elat, erd, eins, eer);
        run_fetch(16'h0010, 1'b0, 0, 16'h0000, 1'b0, 1'b0, -1, lat, rd, ra, ins, er, extra, b1, ba, ia);
        n_cmp++;
        if (lat !== 1 || rd !== 0 || lat !== elat) begin
            n_fail++; $display("FAIL hit_latency: got lat=%0d rd=%0d, want 1 / 0", lat, rd);
        end
        n_cmp++;
        if (ins !== 16'hA5A5 || er !== 1'b0 || extra !== 0) begin
            n_fail++; $display("FAIL hit_data: got %h err=%b extra=%0d, want a5a5 0 0", ins, er, extra);
        end
    endtask

    task automatic test_timeout;
        int lat, rd, extra, elat, erd;
        logic [15:0] ra, ins, ia, eins;
        logic er, b1, ba, eer;
        predict(16'h0020, 1'b0, -1, 16'h0000, 1'b0, elat, erd, eins, eer);
        run_fetch(16'h0020, 1'b0, -1, 16'h0000, 1'b0, 1'b0, -1, lat, rd, ra, ins, er, extra, b1, ba, ia);
        n_cmp++;
        if (lat !== 2 + int'(T) || rd !== 1 || lat !== elat) begin
            n_fail++; $display("FAIL timeout_latency: got lat=%0d rd=%0d, want %0d / 1", lat, rd, 2 + T);
        end
        n_cmp++;
        if (er !== 1'b1 || ins !== 16'h0000 || extra !== 0) begin
            n_fail++; $display("FAIL timeout_error: got err=%b instr=%h extra=%0d, want 1 0000 0", er, ins, extra);
        end
        predict(16'h0010, 1'b0, 0, 16'h0000, 1'b0, elat, erd, eins, eer);
        run_fetch(16'h0010, 1'b0, 0, 16'h0000, 1'b0, 1'b0, -1, lat, rd, ra, ins, er, extra, b1, ba, ia);
        n_cmp++;
        if (lat !== 1 || rd !== 0 || ins !== 16'hA5A5 || ins !== eins) begin
            n_fail++; $display("FAIL timeout_keeps_buffer: got lat=%0d rd=%0d instr=%h, want 1 0 a5a5", lat, rd, ins);
        end
    endtask

    task automatic test_flush;
        int lat, rd, extra, elat, erd;
        logic [15:0] ra, ins, ia, eins;
        logic er, b1, ba, eer;
        predict(16'h0010, 1'b1, 1, 16'h5A5A, 1'b0, elat, erd, eins, eer);
        run_fetch(16'h0010, 1'b1, 1, 16'h5A5A, 1'b0, 1'b0, -1, lat, rd, ra, ins, er, extra, b1, ba, ia);
        n_cmp++;
        if (rd !== 1 || ra !== 16'h0010 || lat !== elat || ins !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL flush_forces_miss: got rd=%0d addr=%h lat=%0d instr=%h, want 1 0010 %0d 5a5a", rd, ra, lat, ins, elat);
        end
        predict(16'h0040, 1'b0, 2, 16'hC0DE, 1'b1, elat, erd, eins, eer);
        run_fetch(16'h0040, 1'b0, 2, 16'hC0DE, 1'b0, 1'b1, -1, lat, rd, ra, ins, er, extra, b1, ba, ia);
        n_cmp++;
        if (lat !== 5 || ins !== 16'hC0DE || er !== 1'b0) begin
            n_fail++; $display("FAIL flush_with_ack_data: got lat=%0d instr=%h err=%b, want 5 c0de 0", lat, ins, er);
        end
        predict(16'h0040, 1'b0, 0, 16'h1111, 1'b0, elat, erd, eins, eer);
        run_fetch(16'h0040, 1'b0, 0, 16'h1111, 1'b0, 1'b0, -1, lat, rd, ra, ins, er, extra, b1, ba, ia);
        n_cmp++;
        if (rd !== 1 || lat !== 3 || ins !== 16'h1111) begin
            n_fail++; $display("FAIL flush_with_ack_invalid: got rd=%0d lat=%0d instr=%h, want 1 3 1111", rd, lat, ins);
        end
    endtask

    task automatic test_busy;
        int lat, rd, extra, elat, erd;
        logic [15:0] ra, ins, ia, eins;
        logic er, b1, ba, eer;
        predict(16'h0050, 1'b0, 3, 16'h7777, 1'b0, elat, erd, eins, eer);
        run_fetch(16'h0050, 1'b0, 3, 16'h7777, 1'b1, 1'b0, 3, lat, rd, ra, ins, er, extra, b1, ba, ia);
        n_cmp++;
        if (rd !== 1 || extra !== 0 || lat !== elat || ins !== 16'h7777 || ra !== 16'h0050) begin
            n_fail++;
            $display("FAIL busy_ignore_fetch: got rd=%0d extra=%0d lat=%0d instr=%h addr=%h, want 1 0 %0d 7777 0050",
                     rd, extra, lat, ins, ra, elat);
        end
        predict(16'h0050, 1'b0, 0, 16'h0000, 1'b0, elat, erd, eins, eer);
        run_fetch(16'h0050, 1'b0, 0, 16'h0000, 1'b0, 1'b0, -1, lat, rd, ra, ins, er, extra, b1, ba, ia);
        n_cmp++;
        if (lat !== 1 || rd !== 0 || ins !== 16'h7777) begin
            n_fail++; $display("FAIL busy_tag_original: got lat=%0d rd=%0d instr=%h, want 1 0 7777", lat, rd, ins);
        end
    endtask

    task automatic test_reset_midfetch;
        int lat, rd, extra, elat, erd, pulses;
        logic [15:0] ra, ins, ia, eins;
        logic er, b1, ba, eer;
        i_fetch = 1'b1; i_addr = 16'h0020;
        tick;
        i_fetch = 1'b0;
        tick;
        tick;
        i_reset = 1'b1;
        tick;
        i_reset = 1'b0; i_mem_ack = 1'b1; i_mem_data = 16'h1234;
        n_cmp++;
        if ({o_instruction, o_instruction_valid, o_fetch_error, o_busy, o_mem_rd, o_mem_addr} !== 35'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got instr=%h v=%b e=%b busy=%b rd=%b maddr=%h, want all zero",
                     o_instruction, o_instruction_valid, o_fetch_error, o_busy, o_mem_rd, o_mem_addr);
        end
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick;
            i_mem_ack = 1'b0;
            if (o_instruction_valid || o_busy || o_instruction !== 16'h0000) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL midreset_stale_ack: got %0d active cycles, want 0", pulses);
        end
        m_valid = 1'b0;
        predict(16'h0010, 1'b0, 0, 16'hBEEF, 1'b0, elat, erd, eins, eer);
        run_fetch(16'h0010, 1'b0, 0, 16'hBEEF, 1'b0, 1'b0, -1, lat, rd, ra, ins, er, extra, b1, ba, ia);
        n_cmp++;
        if (rd !== 1 || lat !== 3 || ins !== 16'hBEEF) begin
            n_fail++; $display("FAIL midreset_next_miss: got rd=%0d lat=%0d instr=%h, want 1 3 beef", rd, lat, ins);
        end
    endtask

    task automatic test_random;
        int lat, rd, extra, elat, erd, aw, r;
        logic [15:0] ra, ins, ia, eins, addr, data;
        logic er, b1, ba, eer;
        bit fl, fa, sp;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                i_flush = 1'b1;
                tick;
                i_flush = 1'b0;
                m_valid = 1'b0;
            end
            addr = 16'(16'h0010 * $urandom_range(1, 4));
            data = 16'($urandom);
            fl = ($urandom_range(0, 4) == 0);
            fa = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 2) == 0);
            r = int'($urandom_range(0, 9));
            if (r == 0) aw = -1;
            else if (r == 1) aw = int'(T) - 1;
            else if (r == 2) aw = int'(T);
            else aw = int'($urandom_range(0, T - 2));
            predict(addr, fl, aw, data, fa, elat, erd, eins, eer);
            run_fetch(addr, fl, aw, data, sp, fa, -1, lat, rd, ra, ins, er, extra, b1, ba, ia);
            n_cmp++;
            if (lat !== elat || rd !== erd) begin
                n_fail++;
                $display("FAIL rand_timing[%0d]: addr=%h got lat=%0d rd=%0d, want %0d / %0d", n, addr, lat, rd, elat, erd);
            end
            n_cmp++;
            if (ins !== eins || er !== eer) begin
                n_fail++;
                $display("FAIL rand_result[%0d]: addr=%h got instr=%h err=%b, want %h / %b", n, addr, ins, er, eins, eer);
            end
            n_cmp++;
            if ((erd == 1 && ra !== addr) || extra !== 0 || ba !== 1'b0 || ia !== eins) begin
                n_fail++;
                $display("FAIL rand_misc[%0d]: got maddr=%h extra=%0d busy_after=%b held=%h, want %h 0 0 %h",
                         n, ra, extra, ba, ia, addr, eins);
            end
        end
    endtask

    initial begin
        test_reset;
        test_miss;
        test_hit;
        test_timeout;
        test_flush;
        test_busy;
        test_reset_midfetch;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
